// File: rtl/shift_pkg.sv
// Shared definitions for the sequential logical shift-left unit.
//   state_e   : FSM states (IDLE, SHIFT, DONE)
//   shamt_w() : shift-amount width for an operand width (log2 of the width)
//   STEP_SLOW : per-cycle shift distance in the default build
//   STEP_FAST : per-cycle shift distance for large remaining counts when
//               SHIFT_LEFT_SEQ_FAST_EN is defined
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int STEP_SLOW = 1;
  localparam int STEP_FAST = 4;

  // Operand width is a power of two, so $clog2 gives the exact log2.
  function automatic int shamt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/shift_left_step.sv
// Combinational single-step logical left shifter (zero fill).
// Ports:
//   acc_i  [N-1:0]        value to shift
//   step_i [SHAMT_W-1:0]  shift distance for this step
//   acc_o  [N-1:0]        acc_i << step_i, bits past the MSB discarded
module shift_left_step #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [N-1:0]       acc_i,
  input  logic [SHAMT_W-1:0] step_i,
  output logic [N-1:0]       acc_o
);

  assign acc_o = acc_i << step_i;

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical shift-left unit with valid/ready on both sides.
// An operand A and shift amount B are accepted in IDLE; the accumulator
// shifts iteratively in SHIFT and the result is presented on Z in DONE
// until the consumer takes it.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   A [N-1:0]         operand
//   B [N-1:0]         shift amount, only B[SHAMT_W-1:0] used
//   out_valid/out_ready output handshake
//   Z [N-1:0]         result register (A << shamt, zero fill)
//   busy              high in SHIFT or DONE
// Configuration macro: SHIFT_LEFT_SEQ_FAST_EN -- when defined, SHIFT moves
// four bits per cycle while at least four remain; results are identical.
import shift_pkg::*;

module shift_left_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         busy
);

  localparam int SHAMT_W = shamt_w(N);
  localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP_SLOW);

  state_e             state_q;
  logic [N-1:0]       acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [SHAMT_W-1:0] step;
  logic [N-1:0]       acc_d;
  logic [SHAMT_W-1:0] cnt_d;
  logic [SHAMT_W-1:0] shamt;

  // Upper bits of B carry no meaning for the shift; fold them so they are
  // visibly consumed.
  logic unused_b;
  assign unused_b = ^B[N-1:SHAMT_W];

  assign shamt = B[SHAMT_W-1:0];

  // Step selection. The chosen step never exceeds cnt_q, so the counter
  // cannot wrap below zero.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    step = STEP_S;
`ifdef SHIFT_LEFT_SEQ_FAST_EN
    if (cnt_q >= SHAMT_W'(STEP_FAST)) step = SHAMT_W'(STEP_FAST);
`endif
  end

  shift_left_step #(
    .N       (N),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .acc_i  (acc_q),
    .step_i (step),
    .acc_o  (acc_d)
  );

  assign cnt_d = cnt_q - step;

  // Single FSM block; handshake flags are registered alongside the state so
  // the outputs come straight from flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= A;
            cnt_q      <= shamt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (shamt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // No accept here even with out_ready high; acc_q keeps the result
          // visible on Z after the return to IDLE.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Z         = acc_q;

endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Multi-cycle logical shift-left unit for the ALU datapath. It is the left-direction counterpart of the combinational logical right shifter. The unit accepts an operand and shift amount over a valid/ready handshake and shifts iteratively in a registered accumulator. It returns the result over a second valid/ready handshake, so the ALU can trade area for latency on SLL/SLLV.

## Interface
- N, 32, operand/result width; power of two, ≥ 8
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B presented
- in_ready  output  1  unit can accept (high only in IDLE)
- A  input  N  operand to shift
- B  input  N  shift amount; only B[SHAMT_W-1:0] used, SHAMT_W = log2(N); upper bits ignored
- out_valid  output  1  Z holds final result
- out_ready  input  1  consumer takes Z
- Z  output  N  result register (A << B[SHAMT_W-1:0], zero fill)
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: acc←A, cnt←B[SHAMT_W-1:0].
  - Next state is DONE if the shift amount is 0, else SHIFT.
- SHIFT: each cycle acc←acc<<step and cnt←cnt−step.
  - step=1 by default; see Configuration for the fast mode.
  - When cnt reaches 0 after the update, go to DONE.
- DONE: out_valid=1 and Z=acc.
  - On out_ready, go to IDLE.
  - While out_ready=0, hold Z and out_valid stable indefinitely.
- Zero fill only; bits shifted past MSB are discarded. No carry/overflow output.
- Z is driven from acc. After the DONE→IDLE handoff, Z keeps the last result until the next accept.
- Inputs are sampled only on the accept edge. A/B changes at any other time have no effect.
- No accept is possible in DONE, even when out_ready is high in the same cycle. The next accept is earliest the cycle after return to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, Z=0, state=IDLE, cnt=0.
- Latency is counted from the accept cycle to the first out_valid cycle:
  - shamt=0: 1 cycle.
  - shamt=k: k+1 cycles.
- Throughput: one operation per latency+1 cycles, with out_ready held high.
- rst mid-operation (SHIFT or DONE) aborts with no result.
  - All outputs return to reset values on the next edge.
  - rst has priority over all handshakes in the same cycle.
- A cnt underflow is impossible by construction. The step never exceeds cnt.

## Configuration
- SHIFT_LEFT_SEQ_FAST_EN defined:
  - In SHIFT, step=4 when cnt≥4, else step=1.
  - SHIFT cycles = ⌊k/4⌋ + (k mod 4), so latency = that count + 1; shamt=0 is still 1.
- Undefined: step is always 1, with the latencies above.
- Results are bit-identical in both builds; only cycle counts differ.

## Structure
- Package shift_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - the SHAMT_W derivation;
  - the step constants STEP_SLOW=1 and STEP_FAST=4.
- Sub-module shift_left_step is a combinational single-step shifter (inputs acc and step; output acc<<step, zero fill). It is instantiated once in the accumulator path.
- The FSM, counter and handshake logic stay in shift_left_seq.

## Test plan
- Basic shift: A=32'h0000_0001, B=5, out_ready=1 → Z=32'h0000_0020, out_valid exactly 6 cycles after accept (fast: 3 cycles).
- Maximum shift: A=32'hFFFF_FFFF, B=31 → Z=32'h8000_0000 after 32 cycles (fast: 11).
- Shift amount zero and ignored upper bits:
  - A=32'hDEAD_BEEF, B=0 → Z=32'hDEAD_BEEF after 1 cycle.
  - A=32'h1, B=32'hFFFF_FFE3 (low bits 3) → Z=32'h8.
- Backpressure: complete A=32'h3, B=2, holding out_ready=0 for 5 cycles.
  - Z=32'hC and out_valid stay stable; in_ready stays 0 throughout.
  - An in_valid pulse during the stall is not accepted.
- Reset mid-operation: A=32'h1, B=20, assert rst 4 cycles after accept.
  - Next cycle: out_valid=0, busy=0, in_ready=1, Z=0.
  - A fresh A=32'h1, B=1 then yields Z=32'h2.
- Back-to-back: two operations with in_valid held high and out_ready=1.
  - Second accept occurs in the cycle after the first DONE→IDLE.
  - Both results are correct, with no dropped or duplicated out_valid.
